finger_scan_ctrl: RTL and testbench
===================================

// Module: finger_scan_ctrl
// PURPOSE
//  Sequences the camera pixel stream through the yuv2rgb converter for one frame, tracks
//  the converter latency, and counts is_finger pixels per piano-key zone inside a row band.
//  At frame end it compares each zone count to a threshold and publishes a key-press mask.
//  Also owns the converter's r_max/g_min/b_max thresholds (cfg-writable, frame-synchronous).
// PARAMETERS
//  FRAME_W     640    pixels per row
//  FRAME_H     480    rows per frame
//  NUM_KEYS    8      key zones, left to right, starting at x=0
//  KEY_W       80     zone width in pixels; x >= NUM_KEYS*KEY_W is outside every zone
//  ROI_Y0      400    first counted row (inclusive)
//  ROI_Y1      479    last counted row (inclusive)
//  CONV_LAT    3      cycles from conv_yuv to matching conv_is_finger
//  HIT_THRESH  200    zone count >= HIT_THRESH => key pressed
// PORTS
//  clk           in   1         system clock
//  rst           in   1         synchronous reset, active-high
//  frame_start   in   1         1-cycle pulse before first pixel of a frame
//  pix_valid     in   1         pix_yuv valid this cycle (raster order, no backpressure)
//  pix_yuv       in   32        packed pixel {V,Y,U,x} as consumed by the converter
//  cfg_we        in   1         threshold write strobe
//  cfg_addr      in   2         0=r_max 1=g_min 2=b_max 3=reserved (write ignored)
//  cfg_data      in   32        threshold value (8.8 scaled, same units as converter r/g/b)
//  conv_yuv      out  32        pixel to converter (registered copy of pix_yuv)
//  r_max/g_min/b_max out 32     active thresholds to converter
//  conv_is_finger in  1         converter classification result
//  key_mask      out  NUM_KEYS  bit k = zone k pressed in last completed frame
//  mask_valid    out  1         1-cycle pulse when key_mask updates
//  busy          out  1         high in any state other than IDLE
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). Reset: state=IDLE, key_mask=0,
//    mask_valid=0, busy=0, conv_yuv=0, zone counters=0, x=y=0, tag pipe cleared,
//    active thresholds and shadows = r_max 32'h8000, g_min 32'h4000, b_max 32'h8000.
//  - cfg writes land in shadow regs next cycle; shadows copy to active outputs on the cycle
//    frame_start is accepted (also in IDLE). cfg_we coincident with frame_start: the new
//    value goes to shadow only, active takes it at the following frame_start.
//  - conv_yuv <= pix_yuv every cycle pix_valid=1. Alongside, a CONV_LAT+1 deep tag pipe
//    carries {valid, in_roi, zone_idx}; result k pairs with conv_is_finger when tag emerges.
//  - in_roi = ROI_Y0<=y<=ROI_Y1 and x < NUM_KEYS*KEY_W; zone_idx = x/KEY_W (counter, no div).
//  - Emerging tag valid & in_roi & conv_is_finger: zone counter += 1, saturating at 16'hFFFF.
//  - x increments per accepted pixel; at x=FRAME_W-1 wraps to 0 and y increments.
//  - FSM: IDLE -frame_start-> SCAN (clear counters, x=y=0).
//    SCAN -pixel (FRAME_W-1,FRAME_H-1) accepted-> DRAIN; pix_valid ignored after last pixel.
//    DRAIN: CONV_LAT+1 cycles until tag pipe empty -> EVAL.
//    EVAL: one zone per cycle, k=0..NUM_KEYS-1, bit k of a staging mask = count>=HIT_THRESH.
//    After zone NUM_KEYS-1 -> DONE: key_mask<=staging, mask_valid=1 for one cycle -> IDLE.
//  - frame_start in SCAN/DRAIN/EVAL: abort, no mask_valid, key_mask retains old value,
//    counters cleared, restart SCAN at x=y=0 (same cycle semantics as from IDLE).
//  - frame_start in DONE: mask still published that cycle, next state SCAN.
//  - Frame end latency: mask_valid asserts exactly CONV_LAT+1+NUM_KEYS+1 cycles after the
//    last pixel's pix_valid cycle.
//  - rst mid-frame: all state to reset values next edge; partial counts discarded.
// TESTING
//  1 Reset, no stimulus -> key_mask=0, mask_valid=0, busy=0, r_max=32'h8000.
//  2 Frame, conv_is_finger=1 for x 80..159 rows 400..479 only -> mask_valid once, key_mask=8'h02,
//    timing = last pixel +13 cycles (defaults).
//  3 Zone 5 gets exactly 199 finger pixels, zone 6 exactly 200 -> key_mask=8'h40.
//  4 Finger pixels only at rows 0..399 and x>=640-equivalent column tail -> key_mask=8'h00.
//  5 frame_start at row 300 of a frame with prior mask 8'h02 -> no pulse, key_mask stays 8'h02,
//    new frame counted from scratch.
//  6 cfg_we addr=1 data=32'h6000 mid-SCAN -> g_min stays 32'h4000 until next frame_start, then 32'h6000;
//    addr=3 write -> no output change.

Source files
------------

// File: rtl/finger_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// finger_scan_ctrl: frame sequencer around yuv2rgb, per-key-zone finger count
// Revision: 1.0
// ---------------------------------------------------------------------------
module finger_scan_ctrl #(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int NUM_KEYS   = 8,
  parameter int KEY_W      = 80,
  parameter int ROI_Y0     = 400,
  parameter int ROI_Y1     = 479,
  parameter int CONV_LAT   = 3,
  parameter int HIT_THRESH = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                pix_valid,
  input  logic [31:0]         pix_yuv,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [31:0]         cfg_data,
  output logic [31:0]         conv_yuv,
  output logic [31:0]         r_max,
  output logic [31:0]         g_min,
  output logic [31:0]         b_max,
  input  logic                conv_is_finger,
  output logic [NUM_KEYS-1:0] key_mask,
  output logic                mask_valid,
  output logic                busy
);

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int PW = $clog2(KEY_W + 1);
  localparam int ZW = $clog2(NUM_KEYS + 1);
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int SW = $clog2(CONV_LAT + NUM_KEYS + 2);

  localparam logic [31:0]   R_MAX_RST  = 32'h0000_8000;
  localparam logic [31:0]   G_MIN_RST  = 32'h0000_4000;
  localparam logic [31:0]   B_MAX_RST  = 32'h0000_8000;
  localparam logic [XW-1:0] X_LAST     = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(FRAME_H - 1);
  localparam logic [YW-1:0] ROI_LO     = YW'(ROI_Y0);
  localparam logic [YW-1:0] ROI_HI     = YW'(ROI_Y1);
  localparam logic [PW-1:0] P_LAST     = PW'(KEY_W - 1);
  localparam logic [ZW-1:0] Z_END      = ZW'(NUM_KEYS);
  localparam logic [SW-1:0] DRAIN_LAST = SW'(CONV_LAT);
  localparam logic [SW-1:0] EVAL_LAST  = SW'(NUM_KEYS - 1);
  localparam logic [15:0]   THRESH     = 16'(HIT_THRESH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] zpos;
  logic [ZW-1:0] zidx;
  logic [SW-1:0] step;
  logic [CONV_LAT:0] tag_v, tag_roi;
  logic [KW-1:0] tag_zone [CONV_LAT+1];
  logic [15:0] cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] staging, staging_upd;
  logic [31:0] r_sh, g_sh, b_sh;

  logic accept, last_pix, in_roi;
  logic [KW-1:0] kidx, ezone;

  assign accept   = (state == SCAN) && pix_valid && !frame_start;
  assign last_pix = accept && (x == X_LAST) && (y == Y_LAST);
  assign in_roi   = (y >= ROI_LO) && (y <= ROI_HI) && (zidx < Z_END);
  assign kidx     = step[KW-1:0];
  assign ezone    = tag_zone[CONV_LAT];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // frame_start wins in every state; from DONE the pulse has already gone out
  always_comb begin
    state_nx   = state;
    mask_valid = (state == DONE);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (frame_start) state_nx = SCAN;
      SCAN:    if (frame_start) state_nx = SCAN;
               else if (last_pix) state_nx = DRAIN;
      DRAIN:   if (frame_start) state_nx = SCAN;
               else if (step == DRAIN_LAST) state_nx = EVAL;
      EVAL:    if (frame_start) state_nx = SCAN;
               else if (step == EVAL_LAST) state_nx = DONE;
      DONE:    state_nx = frame_start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    staging_upd       = staging;
    staging_upd[kidx] = (cnt[kidx] >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step     <= '0;
      staging  <= '0;
      key_mask <= '0;
    end else begin
      step <= (state_nx != state) ? '0 : step + SW'(1);
      if (frame_start) begin
        staging <= '0;
      end else if (state == EVAL) begin
        staging <= staging_upd;
        if (step == EVAL_LAST) key_mask <= staging_upd;
      end
    end
  end

  // Raster position; zone index tracks x/KEY_W without a divider
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      x    <= '0;
      y    <= '0;
      zpos <= '0;
      zidx <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x    <= '0;
        zpos <= '0;
        zidx <= '0;
        y    <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
        if (zpos == P_LAST) begin
          zpos <= '0;
          if (zidx < Z_END) zidx <= zidx + ZW'(1);
        end else begin
          zpos <= zpos + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) conv_yuv <= '0;
    else if (pix_valid) conv_yuv <= pix_yuv;
  end

  // Tags ride alongside the converter so each result finds its pixel's zone
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      tag_v   <= '0;
      tag_roi <= '0;
      for (int i = 0; i <= CONV_LAT; i++) tag_zone[i] <= '0;
    end else begin
      tag_v[0]    <= accept;
      tag_roi[0]  <= in_roi;
      tag_zone[0] <= zidx[KW-1:0];
      for (int i = 1; i <= CONV_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_roi[i]  <= tag_roi[i-1];
        tag_zone[i] <= tag_zone[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
    end else if (tag_v[CONV_LAT] && tag_roi[CONV_LAT] && conv_is_finger
                 && (cnt[ezone] != 16'hFFFF)) begin
      cnt[ezone] <= cnt[ezone] + 16'd1;
    end
  end

  // Writes land in shadows; actives only move at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= R_MAX_RST;
      g_sh  <= G_MIN_RST;
      b_sh  <= B_MAX_RST;
      r_max <= R_MAX_RST;
      g_min <= G_MIN_RST;
      b_max <= B_MAX_RST;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    r_sh <= cfg_data;
          2'd1:    g_sh <= cfg_data;
          2'd2:    b_sh <= cfg_data;
          default: ;
        endcase
      end
      if (frame_start) begin
        r_max <= r_sh;
        g_min <= g_sh;
        b_max <= b_sh;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_finger_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_finger_scan_ctrl: directed frames on a reduced geometry, scoreboarded masks
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_finger_scan_ctrl;

  localparam int FW  = 20;
  localparam int FH  = 8;
  localparam int NK  = 8;
  localparam int KWD = 2;
  localparam int RY0 = 5;
  localparam int RY1 = 7;
  localparam int CL  = 3;
  localparam int THR = 4;
  localparam int LAT = CL + 1 + NK + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_valid;
  logic [31:0]   pix_yuv;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_data;
  logic [31:0]   conv_yuv;
  logic [31:0]   r_max, g_min, b_max;
  logic          conv_is_finger;
  logic [NK-1:0] key_mask;
  logic          mask_valid;
  logic          busy;

  finger_scan_ctrl #(
    .FRAME_W(FW), .FRAME_H(FH), .NUM_KEYS(NK), .KEY_W(KWD),
    .ROI_Y0(RY0), .ROI_Y1(RY1), .CONV_LAT(CL), .HIT_THRESH(THR)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_yuv(pix_yuv), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .conv_yuv(conv_yuv), .r_max(r_max), .g_min(g_min), .b_max(b_max),
    .conv_is_finger(conv_is_finger), .key_mask(key_mask),
    .mask_valid(mask_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: classification is bit 0 of the pixel, CL cycles after conv_yuv
  logic [2:0] fpipe = '0;
  always @(posedge clk) fpipe <= {fpipe[1:0], conv_yuv[0]};
  assign conv_is_finger = fpipe[2];

  typedef struct { logic [NK-1:0] mask; int at; } exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  bit rnd [FW*FH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit finger(input int mode, input int x, input int y);
    case (mode)
      1:       return 1'b1;
      2:       return (x >= 2) && (x <= 3) && (y >= 5);
      3:       return ((x == 10 || x == 11) && y == 5) || (x == 10 && y == 6) ||
                      ((x == 12 || x == 13) && (y == 5 || y == 6));
      4:       return (y <= 4) || (x >= NK*KWD);
      5:       return rnd[y*FW + x];
      default: return 1'b0;
    endcase
  endfunction

  // Drives frame_start then the frame; stops before abort_row if it is in range
  task automatic run_frame(input int mode, input int abort_row, input bit gaps);
    int zc [NK];
    logic [NK-1:0] m;
    logic [31:0] px;
    int last_c = 0;
    bit first = 1'b1;
    for (int k = 0; k < NK; k++) zc[k] = 0;
    frame_start = 1'b1;
    pix_valid   = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        if (y == abort_row) begin
          pix_valid = 1'b0;
          return;
        end
        px    = $urandom();
        px[0] = finger(mode, x, y);
        if (px[0] && y >= RY0 && y <= RY1 && x < NK*KWD) zc[x/KWD]++;
        pix_valid = 1'b1;
        pix_yuv   = px;
        last_c    = cyc;
        @(posedge clk); #1;
        if (first) begin
          check("conv_yuv_copy", conv_yuv, px);
          first = 1'b0;
        end
        if (gaps && (x % 7 == 3)) begin
          pix_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    for (int k = 0; k < NK; k++) m[k] = (zc[k] >= THR);
    sb.push_back('{mask: m, at: last_c + LAT});
    pix_yuv   = 32'hFFFF_FFFF;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_after_frame", {31'b0, busy}, 32'd0);
    check("scoreboard_drained", sb.size(), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mask_valid) begin
      if (sb.size() == 0) begin
        check("mask_valid_unexpected", {31'b0, mask_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("key_mask", key_mask, e.mask);
        check("mask_latency", cyc, e.at);
      end
    end
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_yuv = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_key_mask", key_mask, 32'h0);
    check("rst_mask_valid", {31'b0, mask_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_conv_yuv", conv_yuv, 32'h0);
    check("rst_r_max", r_max, 32'h8000);
    check("rst_g_min", g_min, 32'h4000);
    check("rst_b_max", b_max, 32'h8000);

    // single zone 1 pressed, trailing pixels after the frame must be ignored
    run_frame(2, -1, 1'b0);
    wait_idle();
    check("zone1_mask", key_mask, 32'h02);

    // threshold boundary: zone 5 one short, zone 6 exactly at threshold
    run_frame(3, -1, 1'b1);
    wait_idle();
    check("thresh_edge_mask", key_mask, 32'h40);

    // fingers only above the band and in the tail columns
    run_frame(4, -1, 1'b0);
    wait_idle();
    check("outside_roi_mask", key_mask, 32'h00);

    // abort inside the band; previous mask must survive, new frame counts fresh
    run_frame(2, -1, 1'b0);
    wait_idle();
    run_frame(1, 6, 1'b0);
    check("abort_keeps_mask", key_mask, 32'h02);
    check("abort_busy", {31'b0, busy}, 32'd1);
    run_frame(3, -1, 1'b0);
    wait_idle();
    check("after_abort_mask", key_mask, 32'h40);

    // threshold shadowing, reserved address ignored
    run_frame(0, 2, 1'b0);
    cfg_write(2'd1, 32'h6000);
    repeat (2) @(posedge clk);
    #1;
    check("g_min_held_mid_scan", g_min, 32'h4000);
    cfg_write(2'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < FW*FH; i++) rnd[i] = 1'($urandom_range(0, 1));
    run_frame(5, -1, 1'b1);
    wait_idle();
    check("g_min_after_frame", g_min, 32'h6000);
    check("r_max_untouched", r_max, 32'h8000);
    check("b_max_untouched", b_max, 32'h8000);

    // write coincident with frame_start reaches active only one frame later
    frame_start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'h1234;
    @(posedge clk); #1;
    frame_start = 1'b0; cfg_we = 1'b0;
    check("coincident_r_max_old", r_max, 32'h8000);
    run_frame(1, -1, 1'b0);
    wait_idle();
    check("all_keys_mask", key_mask, 32'hFF);
    check("coincident_r_max_new", r_max, 32'h1234);

    // reset mid-frame
    run_frame(1, 6, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_key_mask", key_mask, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mask_valid", {31'b0, mask_valid}, 32'd0);
    check("midrst_r_max", r_max, 32'h8000);
    check("midrst_g_min", g_min, 32'h4000);
    run_frame(2, -1, 1'b0);
    wait_idle();
    check("post_rst_mask", key_mask, 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
